mux2_serializer: RTL

Sequencing stage directly upstream of the `mux2` 2:1 multiplexer (y = s ? d0[1] : d0[0]). Accepts 2-bit words over a valid/ready handshake, buffers them in a 2-entry FIFO, and drives the mux's data and select inputs so each word is serialized LSB-first over two cycles. Samples the mux output `y` back, emits it as a serial bit stream with valid/last markers, and checks it against the expected bit to detect mux faults.

---
 rtl/mux2_serializer.sv | 73 +++++++
 1 files changed

// File: rtl/mux2_serializer.sv
// mux2_serializer: FIFO-buffered 2-bit word serializer that drives a mux2 (mux_d/mux_s), samples mux_y as out_bit/out_valid/out_last, and flags mismatches on err/err_count
module mux2_serializer #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       in_data,
  output logic             in_ready,
  output logic [1:0]       mux_d,
  output logic             mux_s,
  input  logic             mux_y,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;
  state_t state_q, state_d;
  logic [1:0] mem_q [2];
  logic wr_q, rd_q;
  logic [1:0] cnt_q;
  logic [1:0] mux_d_q;
  logic mux_s_q, out_valid_q, out_bit_q, out_last_q, err_q;
  logic [ERR_W-1:0] err_count_q;
  logic push, pop;
  assign in_ready = !reset && cnt_q != 2'd2;
  assign push = in_valid && in_ready;
  assign pop = state_q != SEND0 && cnt_q != 2'd0;
  always_comb state_d = pop ? SEND0 : state_q == SEND0 ? SEND1 : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cnt_q       <= '0;
      mux_d_q     <= '0;
      mux_s_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[wr_q] <= in_data;
        wr_q        <= !wr_q;
      end
      if (pop) begin
        mux_d_q <= mem_q[rd_q];
        rd_q    <= !rd_q;
      end
      cnt_q       <= cnt_q + {1'b0, push} - {1'b0, pop};
      mux_s_q     <= state_q == SEND0;
      out_valid_q <= state_q != IDLE;
      out_last_q  <= state_q == SEND1;
      err_q       <= state_q != IDLE && mux_y != mux_d_q[mux_s_q];
      if (state_q != IDLE) out_bit_q <= mux_y;
      if (err_q && err_count_q != '1) err_count_q <= err_count_q + 1'b1;
    end
  end
  assign mux_d     = mux_d_q;
  assign mux_s     = mux_s_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign err_count = err_count_q;
endmodule
